// File: rtl/vpg_pattern_engine.sv
// Programmable video timing and test-pattern generator for the pixel-clock domain.
// Counter stage -> pattern stage -> output register; config swaps only on frame boundaries.
module vpg_pattern_engine #(
    parameter int CW         = 12,
    parameter int COLOR_W    = 8,
    parameter int DEF_H_DISP = 1920,
    parameter int DEF_H_FP   = 88,
    parameter int DEF_H_SYNC = 44,
    parameter int DEF_H_BP   = 148,
    parameter int DEF_V_DISP = 1080,
    parameter int DEF_V_FP   = 4,
    parameter int DEF_V_SYNC = 5,
    parameter int DEF_V_BP   = 36,
    parameter int DEF_HS_POL = 1,
    parameter int DEF_VS_POL = 1
) (
    input  logic               gclk,
    input  logic               grst,
    input  logic [CW-1:0]      cfg_h_disp,
    input  logic [CW-1:0]      cfg_h_fporch,
    input  logic [CW-1:0]      cfg_h_sync,
    input  logic [CW-1:0]      cfg_h_bporch,
    input  logic [CW-1:0]      cfg_v_disp,
    input  logic [CW-1:0]      cfg_v_fporch,
    input  logic [CW-1:0]      cfg_v_sync,
    input  logic [CW-1:0]      cfg_v_bporch,
    input  logic               cfg_hs_pol,
    input  logic               cfg_vs_pol,
    input  logic               cfg_load,
    input  logic               enable,
    input  logic [2:0]         mode,
    output logic               cfg_applied,
    output logic               cfg_err,
    output logic               frame_start,
    output logic               vid_de,
    output logic               vid_hs,
    output logic               vid_vs,
    output logic [COLOR_W-1:0] vid_r,
    output logic [COLOR_W-1:0] vid_g,
    output logic [COLOR_W-1:0] vid_b
);
    localparam int TW = CW + 2;

    typedef struct packed {
        logic [CW-1:0] h_disp, h_fp, h_sync, h_bp;
        logic [CW-1:0] v_disp, v_fp, v_sync, v_bp;
        logic          hs_pol, vs_pol;
    } timing_t;

    typedef struct packed {
        logic               de, hs, vs, fs;
        logic [COLOR_W-1:0] r, g, b;
    } pix_t;

    localparam timing_t DEF_T = '{
        h_disp: CW'(DEF_H_DISP), h_fp: CW'(DEF_H_FP), h_sync: CW'(DEF_H_SYNC), h_bp: CW'(DEF_H_BP),
        v_disp: CW'(DEF_V_DISP), v_fp: CW'(DEF_V_FP), v_sync: CW'(DEF_V_SYNC), v_bp: CW'(DEF_V_BP),
        hs_pol: 1'(DEF_HS_POL), vs_pol: 1'(DEF_VS_POL)};
    localparam pix_t IDLE_RST = '{de: 1'b0, hs: 1'(DEF_HS_POL == 0), vs: 1'(DEF_VS_POL == 0),
                                  fs: 1'b0, r: '0, g: '0, b: '0};

    timing_t act, pend, cfg_in;
    logic    pend_valid, en_d, s1_vld;
    logic [2:0]    mode_act, bar_idx;
    logic [CW-1:0] pos, bar_cnt, bar_w;
    logic [TW-1:0] h_cnt, v_cnt, h_total, v_total, hs_beg, hs_end, vs_beg, vs_end;
    logic [CW:0]   pos_nxt;
    logic run, rise, h_last, v_last, frame_end, bound, cfg_ok, in_de, hs_on, vs_on;
    logic [COLOR_W-1:0] pr, pg, pb;
    pix_t s1, s2, idle;

    assign cfg_in = '{h_disp: cfg_h_disp, h_fp: cfg_h_fporch, h_sync: cfg_h_sync, h_bp: cfg_h_bporch,
                      v_disp: cfg_v_disp, v_fp: cfg_v_fporch, v_sync: cfg_v_sync, v_bp: cfg_v_bporch,
                      hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};
    assign cfg_ok = (cfg_h_disp >= CW'(8)) && (cfg_h_sync != '0) && (cfg_v_disp != '0) && (cfg_v_sync != '0);

    assign h_total = TW'(act.h_disp) + TW'(act.h_fp) + TW'(act.h_sync) + TW'(act.h_bp);
    assign v_total = TW'(act.v_disp) + TW'(act.v_fp) + TW'(act.v_sync) + TW'(act.v_bp);
    assign hs_beg  = TW'(act.h_disp) + TW'(act.h_fp);
    assign hs_end  = hs_beg + TW'(act.h_sync);
    assign vs_beg  = TW'(act.v_disp) + TW'(act.v_fp);
    assign vs_end  = vs_beg + TW'(act.v_sync);

    // The cycle enable rises is spent applying config/mode, so the first counted pixel already uses it.
    assign run       = enable & en_d;
    assign rise      = enable & ~en_d;
    assign h_last    = (h_cnt == h_total - TW'(1));
    assign v_last    = (v_cnt == v_total - TW'(1));
    assign frame_end = run & h_last & v_last;
    assign bound     = frame_end | rise;
    assign bar_w     = act.h_disp >> 3;
    assign pos_nxt   = {1'b0, pos} + (CW+1)'(4);

    always_ff @(posedge gclk) begin
        if (grst) begin
            act         <= DEF_T;
            pend        <= DEF_T;
            pend_valid  <= 1'b0;
            mode_act    <= '0;
            pos         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            en_d        <= 1'b1;
            cfg_applied <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            en_d        <= enable;
            cfg_err     <= cfg_load & ~cfg_ok;
            cfg_applied <= bound & pend_valid;
            if (bound) begin
                mode_act <= mode;
                if (pend_valid) act <= pend;
            end
            if (cfg_load && cfg_ok) begin
                pend       <= cfg_in;
                pend_valid <= 1'b1;
            end else if (bound) begin
                pend_valid <= 1'b0;
            end
            if (!run) begin
                h_cnt   <= '0;
                v_cnt   <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                pos     <= '0;
            end else begin
                if (h_last) begin
                    h_cnt   <= '0;
                    bar_cnt <= '0;
                    bar_idx <= '0;
                    v_cnt   <= v_last ? '0 : v_cnt + TW'(1);
                end else begin
                    h_cnt <= h_cnt + TW'(1);
                    if (bar_cnt == bar_w - CW'(1)) begin
                        bar_cnt <= '0;
                        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt + CW'(1);
                    end
                end
                if (frame_end) pos <= (pos_nxt >= {1'b0, act.h_disp}) ? '0 : pos_nxt[CW-1:0];
            end
        end
    end

    assign in_de = (h_cnt < TW'(act.h_disp)) && (v_cnt < TW'(act.v_disp));
    assign hs_on = (h_cnt >= hs_beg) && (h_cnt < hs_end);
    assign vs_on = (v_cnt >= vs_beg) && (v_cnt < vs_end);

    always_comb begin
        pr = '0;
        pg = '0;
        pb = '0;
        case (mode_act)
            3'd1: {pr, pg, pb} = '1;
            3'd2: begin
                pr = {COLOR_W{~bar_idx[1]}};
                pg = {COLOR_W{~bar_idx[2]}};
                pb = {COLOR_W{~bar_idx[0]}};
            end
            3'd3: begin
                pr = h_cnt[COLOR_W-1:0];
                pg = h_cnt[COLOR_W-1:0];
                pb = h_cnt[COLOR_W-1:0];
            end
            3'd4: if (h_cnt[5] ^ v_cnt[5]) {pr, pg, pb} = '1;
            3'd5: if (h_cnt >= TW'(pos) && h_cnt < TW'(pos) + TW'(16)) {pr, pg, pb} = '1;
            default: ;
        endcase
        if (!in_de) {pr, pg, pb} = '0;
    end

    assign idle = '{de: 1'b0, hs: ~act.hs_pol, vs: ~act.vs_pol, fs: 1'b0, r: '0, g: '0, b: '0};

    // Gating sits on the output register so a falling enable still shows one in-flight pixel.
    always_ff @(posedge gclk) begin
        if (grst) begin
            s1     <= IDLE_RST;
            s2     <= IDLE_RST;
            s1_vld <= 1'b0;
        end else begin
            s1     <= '{de: in_de, hs: hs_on ^ ~act.hs_pol, vs: vs_on ^ ~act.vs_pol,
                        fs: (h_cnt == '0) && (v_cnt == '0), r: pr, g: pg, b: pb};
            s1_vld <= run;
            s2     <= s1_vld ? s1 : idle;
        end
    end

    assign vid_de      = s2.de;
    assign vid_hs      = s2.hs;
    assign vid_vs      = s2.vs;
    assign frame_start = s2.fs;
    assign vid_r       = s2.r;
    assign vid_g       = s2.g;
    assign vid_b       = s2.b;
endmodule
